// File: rtl/uart_rx_ctrl.sv
// UART receive controller: 2-flop sync, mid-bit sampling, 11-bit frame word; parity via UART_RX_CTRL_PARITY_EN.
// Latency: wr one cycle after the stop-bit sample; no backpressure, so the consumer must latch rx on wr.
module uart_rx_ctrl #(
    parameter int CLKS_PER_BIT = 868,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic        clk,
    input  logic        ret,
    input  logic        rxd,
    input  logic        en,
    output logic        wr,
    output logic [10:0] rx,
    output logic        busy,
    output logic        frame_err,
    output logic        parity_err
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_CTRL_PARITY_EN
        PARITY,
`endif
        STOP,
        BRK
    } state_t;

    state_t        state;
    logic          sync1;
    logic          rxs;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic          perr;
    logic          expire;

    assign expire = (cnt == CW'(1));

`ifdef UART_RX_CTRL_PARITY_EN
    assign perr = (^rx[10:2]) != PARITY_ODD;
`else
    localparam bit unused_parity_odd = PARITY_ODD;
    assign perr = 1'b0;
`endif

    always_ff @(posedge clk or negedge ret) begin
        if (!ret) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rxd;
            rxs   <= sync1;
        end
    end

    always_ff @(posedge clk or negedge ret) begin
        if (!ret) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            rx         <= '0;
            wr         <= 1'b0;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            wr         <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            if (!en) begin
                // Abandon any partial frame; the last good word is only invalidated if one was in flight.
                if (state != IDLE) rx[0] <= 1'b0;
                state   <= IDLE;
                busy    <= 1'b0;
                cnt     <= '0;
                bit_idx <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!rxs) begin
                            cnt   <= HALF;
                            state <= START;
                            busy  <= 1'b1;
                        end
                    end
                    START: begin
                        if (expire) begin
                            if (rxs) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state   <= DATA;
                                cnt     <= FULL;
                                bit_idx <= '0;
                            end
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    DATA: begin
                        if (expire) begin
                            rx[4'(bit_idx) + 4'd2] <= rxs;
                            cnt <= FULL;
                            if (bit_idx == 3'd7) begin
`ifdef UART_RX_CTRL_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
`ifdef UART_RX_CTRL_PARITY_EN
                    PARITY: begin
                        if (expire) begin
                            rx[10] <= rxs;
                            cnt    <= FULL;
                            state  <= STOP;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
`endif
                    STOP: begin
                        if (expire) begin
                            rx[1]      <= 1'b0;
                            rx[0]      <= rxs & ~perr;
                            wr         <= 1'b1;
                            frame_err  <= ~rxs;
                            parity_err <= perr;
                            // Sampling mid-stop re-arms early so back-to-back frames are caught.
                            busy       <= ~rxs;
                            state      <= rxs ? IDLE : BRK;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    BRK: begin
                        if (rxs) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at 16 clocks per bit, even parity.
module tb_uart_rx_ctrl;
    localparam int N = 16;
    localparam int H = N / 2;
`ifdef UART_RX_CTRL_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    // Two synchroniser edges plus the IDLE edge precede T0's decision.
    localparam int LAT = 3 + H + (NB - 1) * N;

    logic        clk = 1'b0;
    logic        ret = 1'b1;
    logic        rxd = 1'b1;
    logic        en  = 1'b0;
    logic        wr;
    logic [10:0] rx;
    logic        busy;
    logic        frame_err;
    logic        parity_err;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int          wr_cnt = 0;
    int          wr_cyc_a [16];
    logic [10:0] wr_rx_a  [16];
    logic        wr_fe_a  [16];
    logic        wr_pe_a  [16];
    int          busy_rise = -1;
    int          busy_fall = -1;
    logic        busy_q = 1'b0;

    uart_rx_ctrl #(.CLKS_PER_BIT(N), .PARITY_ODD(1'b0)) dut (
        .clk(clk), .ret(ret), .rxd(rxd), .en(en), .wr(wr), .rx(rx),
        .busy(busy), .frame_err(frame_err), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr && wr_cnt < 16) begin
            wr_cyc_a[wr_cnt] <= cyc;
            wr_rx_a[wr_cnt]  <= rx;
            wr_fe_a[wr_cnt]  <= frame_err;
            wr_pe_a[wr_cnt]  <= parity_err;
        end
        if (wr) wr_cnt <= wr_cnt + 1;
        if (busy && !busy_q) busy_rise <= cyc;
        if (!busy && busy_q) busy_fall <= cyc;
        busy_q <= busy;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic v);
        rxd = v;
        tick(N);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, output int st);
        st = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_CTRL_PARITY_EN
        send_bit(p);
`endif
        send_bit(s);
    endtask

    task automatic test_reset();
        int b;
        #1 ret = 1'b0;
        en = 1'b1;
        tick(3);
        checks++; if (wr !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b want 0", wr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (rx !== 11'h000) begin errors++; $display("FAIL reset_rx: got %h want 000", rx); end
        checks++; if (frame_err !== 1'b0 || parity_err !== 1'b0) begin errors++; $display("FAIL reset_err: got fe=%b pe=%b want 0 0", frame_err, parity_err); end
        ret = 1'b1;
        tick(2);
        b = wr_cnt;
        send_bit(1'b0);
        rxd = 1'b1;
        tick(3 * N);
        checks++; if (rx !== 11'h01C) begin errors++; $display("FAIL partial_rx: got %h want 01c", rx); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", busy); end
        ret = 1'b0;
        #1;
        checks++; if (rx !== 11'h000 || busy !== 1'b0 || wr !== 1'b0) begin errors++; $display("FAIL async_reset: got rx=%h busy=%b wr=%b want 000 0 0", rx, busy, wr); end
        tick(2);
        ret = 1'b1;
        tick(3 * N);
        checks++; if (wr_cnt !== b) begin errors++; $display("FAIL reset_no_wr: got %0d strobes want %0d", wr_cnt, b); end
    endtask

    task automatic test_good_byte();
        int b, st;
        b = wr_cnt;
        send_frame(8'hA5, 1'b0, 1'b1, st);
        tick(4);
        checks++; if (wr_cnt !== b + 1) begin errors++; $display("FAIL good_count: got %0d want %0d", wr_cnt, b + 1); end
        checks++; if (wr_cyc_a[b] - st !== LAT) begin errors++; $display("FAIL good_latency: got %0d want %0d", wr_cyc_a[b] - st, LAT); end
        checks++; if (wr_rx_a[b] !== 11'h295) begin errors++; $display("FAIL good_rx: got %h want 295", wr_rx_a[b]); end
        checks++; if (wr_fe_a[b] !== 1'b0 || wr_pe_a[b] !== 1'b0) begin errors++; $display("FAIL good_err: got fe=%b pe=%b want 0 0", wr_fe_a[b], wr_pe_a[b]); end
        checks++; if (busy_rise - st !== 3) begin errors++; $display("FAIL busy_rise: got %0d want 3", busy_rise - st); end
        checks++; if (busy_fall !== wr_cyc_a[b]) begin errors++; $display("FAIL busy_fall: got %0d want %0d", busy_fall, wr_cyc_a[b]); end
        checks++; if (rx !== 11'h295) begin errors++; $display("FAIL good_hold: got %h want 295", rx); end
    endtask

    task automatic test_parity_err();
        int b, st;
        b = wr_cnt;
        send_frame(8'h01, 1'b0, 1'b1, st);
        tick(4);
        checks++; if (wr_cnt !== b + 1) begin errors++; $display("FAIL par_count: got %0d want %0d", wr_cnt, b + 1); end
`ifdef UART_RX_CTRL_PARITY_EN
        checks++; if (wr_rx_a[b] !== 11'h004) begin errors++; $display("FAIL par_rx: got %h want 004", wr_rx_a[b]); end
        checks++; if (wr_pe_a[b] !== 1'b1 || wr_fe_a[b] !== 1'b0) begin errors++; $display("FAIL par_flags: got pe=%b fe=%b want 1 0", wr_pe_a[b], wr_fe_a[b]); end
`else
        checks++; if (wr_rx_a[b] !== 11'h005) begin errors++; $display("FAIL nopar_rx: got %h want 005", wr_rx_a[b]); end
        checks++; if (wr_pe_a[b] !== 1'b0 || wr_fe_a[b] !== 1'b0) begin errors++; $display("FAIL nopar_flags: got pe=%b fe=%b want 0 0", wr_pe_a[b], wr_fe_a[b]); end
`endif
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL par_pulse: got %b want 0 after strobe", parity_err); end
    endtask

    task automatic test_break();
        int b, st;
        b = wr_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, st);
        tick(5 * N);
        checks++; if (wr_cnt !== b + 1) begin errors++; $display("FAIL brk_count: got %0d want %0d", wr_cnt, b + 1); end
        checks++; if (wr_rx_a[b] !== 11'h0F0) begin errors++; $display("FAIL brk_rx: got %h want 0f0", wr_rx_a[b]); end
        checks++; if (wr_fe_a[b] !== 1'b1 || wr_pe_a[b] !== 1'b0) begin errors++; $display("FAIL brk_flags: got fe=%b pe=%b want 1 0", wr_fe_a[b], wr_pe_a[b]); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL brk_busy: got %b want 1", busy); end
        rxd = 1'b1;
        tick(5);
        checks++; if (busy !== 1'b0 || wr_cnt !== b + 1) begin errors++; $display("FAIL brk_release: got busy=%b strobes=%0d want 0 %0d", busy, wr_cnt, b + 1); end
        b = wr_cnt;
        send_frame(8'h96, 1'b0, 1'b1, st);
        tick(4);
        checks++; if (wr_cnt !== b + 1) begin errors++; $display("FAIL after_brk_count: got %0d want %0d", wr_cnt, b + 1); end
        checks++; if (wr_rx_a[b] !== 11'h259 || wr_fe_a[b] !== 1'b0) begin errors++; $display("FAIL after_brk_rx: got %h fe=%b want 259 0", wr_rx_a[b], wr_fe_a[b]); end
        checks++; if (wr_cyc_a[b] - st !== LAT) begin errors++; $display("FAIL after_brk_latency: got %0d want %0d", wr_cyc_a[b] - st, LAT); end
    endtask

    task automatic test_glitch();
        int b;
        b = wr_cnt;
        rxd = 1'b0;
        tick(3);
        rxd = 1'b1;
        tick(2 * N);
        checks++; if (wr_cnt !== b || busy !== 1'b0) begin errors++; $display("FAIL glitch: got strobes=%0d busy=%b want %0d 0", wr_cnt, busy, b); end
        checks++; if (rx !== 11'h259) begin errors++; $display("FAIL glitch_rx: got %h want 259", rx); end
    endtask

    task automatic test_abort();
        int b;
        b = wr_cnt;
        send_bit(1'b0);
        rxd = 1'b1;
        tick(2 * N);
        en = 1'b0;
        tick(1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        checks++; if (rx !== 11'h25C) begin errors++; $display("FAIL abort_rx: got %h want 25c", rx); end
        en = 1'b1;
        tick(3 * N);
        checks++; if (wr_cnt !== b || busy !== 1'b0) begin errors++; $display("FAIL abort_no_wr: got strobes=%0d busy=%b want %0d 0", wr_cnt, busy, b); end
    endtask

    task automatic test_back_to_back();
        int b, s1, s2;
        b = wr_cnt;
        send_frame(8'h55, 1'b0, 1'b1, s1);
        send_frame(8'hFF, 1'b0, 1'b1, s2);
        tick(4);
        checks++; if (wr_cnt !== b + 2) begin errors++; $display("FAIL b2b_count: got %0d want %0d", wr_cnt, b + 2); end
        checks++; if (wr_rx_a[b] !== 11'h155) begin errors++; $display("FAIL b2b_rx0: got %h want 155", wr_rx_a[b]); end
        checks++; if (wr_rx_a[b + 1] !== 11'h3FD) begin errors++; $display("FAIL b2b_rx1: got %h want 3fd", wr_rx_a[b + 1]); end
        checks++; if (wr_cyc_a[b + 1] - wr_cyc_a[b] !== NB * N) begin errors++; $display("FAIL b2b_gap: got %0d want %0d", wr_cyc_a[b + 1] - wr_cyc_a[b], NB * N); end
        checks++; if (wr_cyc_a[b] - s1 !== LAT) begin errors++; $display("FAIL b2b_latency: got %0d want %0d", wr_cyc_a[b] - s1, LAT); end
        checks++; if (wr_fe_a[b + 1] !== 1'b0 || wr_pe_a[b + 1] !== 1'b0) begin errors++; $display("FAIL b2b_err: got fe=%b pe=%b want 0 0", wr_fe_a[b + 1], wr_pe_a[b + 1]); end
    endtask

    initial begin
        test_reset();
        test_good_byte();
        test_parity_err();
        test_break();
        test_glitch();
        test_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
